// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port byte-writable SRAM and its clear engine.
package sram_pkg;

    // Width of one byte lane; write enables are granted per lane.
    localparam int BYTE_W = 8;

    // Clear engine states.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sram_clear_ctrl.sv
// Zero-fill engine: walks every word address once, one word per cycle,
// and presents a forced all-lanes write of zero data to the array.
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int N_ENTRIES  = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic                         clr_we_o,
    output logic [$clog2(N_ENTRIES)-1:0] clr_addr_o,
    output logic [DATA_WIDTH-1:0]        clr_data_o
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // Clear FSM: state, address counter and registered busy flag move together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            busy_q  <= (INIT_CLEAR != 0) ? 1'b1 : 1'b0;
            cnt_q   <= {AW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                    end
                    cnt_q <= {AW{1'b0}};
                end
                S_CLEAR: begin
                    // clear_i is deliberately not looked at here: no restart.
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= {AW{1'b0}};
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;
    assign clr_data_o = {DATA_WIDTH{1'b0}};

endmodule

// File: rtl/sram_dp_be.sv
// Dual-port byte-writable RAM: port A read/write with byte enables (read-first),
// port B read-only, optional output register, built-in zero-fill engine.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    input  logic                         a_en_i,
    input  logic [DATA_WIDTH/8-1:0]      a_we_i,
    input  logic [$clog2(N_ENTRIES)-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0]        a_data_i,
    output logic [DATA_WIDTH-1:0]        a_data_o,
    output logic                         a_rvalid_o,
    input  logic                         b_en_i,
    input  logic [$clog2(N_ENTRIES)-1:0] b_addr_i,
    output logic [DATA_WIDTH-1:0]        b_data_o,
    output logic                         b_rvalid_o
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int NB = DATA_WIDTH / BYTE_W;

    logic                  busy_s;
    logic                  clr_we_s;
    logic [AW-1:0]         clr_addr_s;
    logic [DATA_WIDTH-1:0] clr_data_s;

    logic                  a_acc_s;
    logic                  a_rd_s;
    logic                  b_acc_s;
    logic [NB-1:0]         wr_be_s;
    logic [AW-1:0]         pa_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [DATA_WIDTH-1:0] ram_a_s;
    logic [DATA_WIDTH-1:0] ram_b_s;

    logic [DATA_WIDTH-1:0] a_data_q1;
    logic                  a_rv_q1;
    logic [DATA_WIDTH-1:0] b_data_q1;
    logic                  b_rv_q1;

    sram_clear_ctrl #(
        .N_ENTRIES  (N_ENTRIES),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .busy_o     (busy_s),
        .clr_we_o   (clr_we_s),
        .clr_addr_o (clr_addr_s),
        .clr_data_o (clr_data_s)
    );

    assign busy_o  = busy_s;
    assign a_acc_s = a_en_i & ~busy_s;
    assign b_acc_s = b_en_i & ~busy_s;
    assign a_rd_s  = a_acc_s & (a_we_i == {NB{1'b0}});

    // Port A mux: the clear engine owns the port while busy, user otherwise.
    always_comb begin
        wr_be_s   = {NB{1'b0}};
        pa_addr_s = a_addr_i;
        wr_data_s = a_data_i;
        if (clr_we_s) begin
            wr_be_s   = {NB{1'b1}};
            pa_addr_s = clr_addr_s;
            wr_data_s = clr_data_s;
        end else if (a_acc_s) begin
            wr_be_s   = a_we_i;
            pa_addr_s = a_addr_i;
            wr_data_s = a_data_i;
        end else begin
            wr_be_s   = {NB{1'b0}};
            pa_addr_s = a_addr_i;
            wr_data_s = a_data_i;
        end
    end

    // One narrow array per byte lane so each lane carries its own write enable.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [BYTE_W-1:0] lane_mem [N_ENTRIES];

        // Lane write on port A; reads below see the pre-edge contents (read-first).
        always_ff @(posedge clk_i) begin
            if (wr_be_s[k]) begin
                lane_mem[pa_addr_s] <= wr_data_s[k*BYTE_W +: BYTE_W];
            end
        end

        assign ram_a_s[k*BYTE_W +: BYTE_W] = lane_mem[pa_addr_s];
        assign ram_b_s[k*BYTE_W +: BYTE_W] = lane_mem[b_addr_i];
    end

    // First read stage: capture on accept, hold otherwise; rvalid only for real reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_data_q1 <= {DATA_WIDTH{1'b0}};
            a_rv_q1   <= 1'b0;
            b_data_q1 <= {DATA_WIDTH{1'b0}};
            b_rv_q1   <= 1'b0;
        end else begin
            if (a_acc_s) begin
                a_data_q1 <= ram_a_s;
            end
            if (b_acc_s) begin
                b_data_q1 <= ram_b_s;
            end
            a_rv_q1 <= a_rd_s;
            b_rv_q1 <= b_acc_s;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] a_data_q2;
        logic                  a_rv_q2;
        logic [DATA_WIDTH-1:0] b_data_q2;
        logic                  b_rv_q2;

        // Second stage reloads from the first every cycle, rvalid delayed alongside.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_data_q2 <= {DATA_WIDTH{1'b0}};
                a_rv_q2   <= 1'b0;
                b_data_q2 <= {DATA_WIDTH{1'b0}};
                b_rv_q2   <= 1'b0;
            end else begin
                a_data_q2 <= a_data_q1;
                a_rv_q2   <= a_rv_q1;
                b_data_q2 <= b_data_q1;
                b_rv_q2   <= b_rv_q1;
            end
        end

        assign a_data_o   = a_data_q2;
        assign a_rvalid_o = a_rv_q2;
        assign b_data_o   = b_data_q2;
        assign b_rvalid_o = b_rv_q2;
    end else begin : g_no_out_reg
        assign a_data_o   = a_data_q1;
        assign a_rvalid_o = a_rv_q1;
        assign b_data_o   = b_data_q1;
        assign b_rvalid_o = b_rv_q1;
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: two instances (OUT_REG=0 and OUT_REG=1)
// share the same stimulus; each is checked at its own read latency.
module tb_sram_dp_be;

    localparam int DW = 32;
    localparam int N  = 16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          clear   = 1'b0;
    logic          a_en    = 1'b0;
    logic [3:0]    a_we    = 4'h0;
    logic [3:0]    a_addr  = 4'h0;
    logic [DW-1:0] a_wdata = 32'h0;
    logic          b_en    = 1'b0;
    logic [3:0]    b_addr  = 4'h0;

    logic          busy0, busy1;
    logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic          a_rv0, a_rv1, b_rv0, b_rv1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_dp_be #(.DATA_WIDTH(DW), .N_ENTRIES(N), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy0),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_data_o(a_rd0), .a_rvalid_o(a_rv0),
        .b_en_i(b_en), .b_addr_i(b_addr), .b_data_o(b_rd0), .b_rvalid_o(b_rv0)
    );

    sram_dp_be #(.DATA_WIDTH(DW), .N_ENTRIES(N), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy1),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_data_o(a_rd1), .a_rvalid_o(a_rv1),
        .b_en_i(b_en), .b_addr_i(b_addr), .b_data_o(b_rd1), .b_rvalid_o(b_rv1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_b(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        b_en   = 1'b1;
        b_addr = addr;
        @(negedge clk);
        b_en = 1'b0;
        check({tag, "_b0_data"}, b_rd0, exp);
        check({tag, "_b0_rv"}, {31'b0, b_rv0}, 32'd1);
        @(negedge clk);
        check({tag, "_b1_data"}, b_rd1, exp);
        check({tag, "_b1_rv"}, {31'b0, b_rv1}, 32'd1);
        check({tag, "_b0_rv_once"}, {31'b0, b_rv0}, 32'd0);
    endtask

    task automatic read_a(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        a_en   = 1'b1;
        a_we   = 4'h0;
        a_addr = addr;
        @(negedge clk);
        a_en = 1'b0;
        check({tag, "_a0_data"}, a_rd0, exp);
        check({tag, "_a0_rv"}, {31'b0, a_rv0}, 32'd1);
        @(negedge clk);
        check({tag, "_a1_data"}, a_rd1, exp);
        check({tag, "_a1_rv"}, {31'b0, a_rv1}, 32'd1);
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] we);
        a_en    = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_wdata = data;
        @(negedge clk);
        a_en = 1'b0;
        a_we = 4'h0;
        check("write_no_rv", {31'b0, a_rv0}, 32'd0);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
        check({tag, "_busy1_low"}, {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        int n;
        int rv_seen;

        // 1. Reset values, then automatic zero-fill.
        @(negedge clk);
        check("rst_a0", a_rd0, 32'h0);
        check("rst_b1", b_rd1, 32'h0);
        check("rst_rv", {28'b0, a_rv0, a_rv1, b_rv0, b_rv1}, 32'h0);
        check("rst_busy", {30'b0, busy0, busy1}, 32'h3);
        rst = 1'b0;
        count_busy("init");
        for (int i = 0; i < N; i++) begin
            read_b(4'(i), 32'h0, "fill");
        end

        // 2. Byte-enable merge and output hold.
        write_a(4'd5, 32'hAABBCCDD, 4'hF);
        write_a(4'd5, 32'h11223344, 4'b0101);
        read_a(4'd5, 32'hAA22CC44, "merge");
        read_b(4'd5, 32'hAA22CC44, "merge");
        @(negedge clk);
        check("hold_b0", b_rd0, 32'hAA22CC44);
        check("hold_b0_rv", {31'b0, b_rv0}, 32'd0);

        // 3. Same-address write on A and read on B in one cycle.
        a_en = 1'b1; a_we = 4'hF; a_addr = 4'd3; a_wdata = 32'hDEADBEEF;
        b_en = 1'b1; b_addr = 4'd3;
        @(negedge clk);
        a_en = 1'b0; a_we = 4'h0; b_en = 1'b0;
        check("rbw_b0_data", b_rd0, 32'h0);
        check("rbw_b0_rv", {31'b0, b_rv0}, 32'd1);
        check("rbw_a0_old", a_rd0, 32'h0);
        check("rbw_a0_no_rv", {31'b0, a_rv0}, 32'd0);
        @(negedge clk);
        check("rbw_b1_data", b_rd1, 32'h0);
        read_b(4'd3, 32'hDEADBEEF, "rbw_after");

        // 4. Back-to-back port A reads: latency 1 vs 2.
        write_a(4'd1, 32'd1, 4'hF);
        write_a(4'd2, 32'd2, 4'hF);
        write_a(4'd3, 32'd3, 4'hF);
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                a_en = 1'b1; a_we = 4'h0; a_addr = 4'(c + 1);
            end else begin
                a_en = 1'b0;
            end
            @(negedge clk);
            check("b2b_a0_rv", {31'b0, a_rv0}, {31'b0, (c < 3)});
            if (c < 3) check("b2b_a0_data", a_rd0, 32'(c + 1));
            check("b2b_a1_rv", {31'b0, a_rv1}, {31'b0, (c >= 1 && c <= 3)});
            if (c >= 1 && c <= 3) check("b2b_a1_data", a_rd1, 32'(c));
        end

        // 5. Clear with a held write to 7 and a second clear mid-way.
        clear = 1'b1;
        a_en = 1'b1; a_we = 4'hF; a_addr = 4'd7; a_wdata = 32'hCAFEF00D;
        b_en = 1'b1; b_addr = 4'd7;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        rv_seen = 0;
        while (busy0 && n < 100) begin
            clear = (n == 5);
            if (n == 12) begin
                a_en = 1'b0; a_we = 4'h0; b_en = 1'b0;
            end
            @(negedge clk);
            n++;
            if (a_rv0 || b_rv0) rv_seen++;
        end
        clear = 1'b0; a_en = 1'b0; a_we = 4'h0; b_en = 1'b0;
        check("clr_busy_cycles", 32'(n), 32'd16);
        check("clr_no_rv", 32'(rv_seen), 32'd0);
        read_b(4'd7, 32'h0, "clr_7");
        read_a(4'd7, 32'h0, "clr_7");
        read_b(4'd5, 32'h0, "clr_5");

        // 6. Reset in the middle of a clear.
        write_a(4'd12, 32'h12345678, 4'hF);
        read_b(4'd12, 32'h12345678, "pre_rst");
        read_a(4'd12, 32'h12345678, "pre_rst");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_hold_b0", b_rd0, 32'h12345678);
        check("mid_busy", {31'b0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_b0", b_rd0, 32'h0);
        check("mid_rst_b1", b_rd1, 32'h0);
        check("mid_rst_a0", a_rd0, 32'h0);
        check("mid_rst_a1", a_rd1, 32'h0);
        check("mid_rst_busy", {30'b0, busy0, busy1}, 32'h3);
        @(negedge clk);
        rst = 1'b0;
        count_busy("rst_restart");
        read_b(4'd12, 32'h0, "restart_12");
        read_b(4'd0, 32'h0, "restart_0");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
